// File: rtl/ifetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_ctrl_pkg
//   Shared widths, constants and FSM encoding for the instruction-fetch
//   controller and its output slot.
//   Contents:
//     PC_WIDTH / INST_WIDTH  default address and instruction widths
//     PC_INC                 sequential PC step in bytes
//     if_state_e             fetch FSM state encoding (2 bits)
// -----------------------------------------------------------------------------
package ifetch_ctrl_pkg;

   localparam int unsigned PC_WIDTH   = 32;
   localparam int unsigned INST_WIDTH = 32;
   localparam int unsigned PC_INC     = 4;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // no request outstanding
      S_WAIT = 2'd1,   // one request outstanding, response will be kept
      S_DROP = 2'd2    // one request outstanding, response will be discarded
   } if_state_e;

endpackage : ifetch_ctrl_pkg

// File: rtl/ifetch_ctrl_obuf.sv
// -----------------------------------------------------------------------------
// ifetch_obuf
//   One-entry valid/ready holding slot for a fetched instruction and its PC.
//   Contents are frozen while valid_o=1 and the consumer is not ready.
//   Ports:
//     clk      in   clock
//     rst_n    in   synchronous reset, active low
//     load_i   in   capture inst_i / pc_i and raise valid_o
//     inst_i   in   instruction to capture
//     pc_i     in   PC of inst_i
//     flush_i  in   drop the held entry (valid_o cleared next cycle)
//     ready_i  in   consumer accepts the held entry
//     valid_o  out  entry valid
//     inst_o   out  held instruction
//     pc_o     out  held PC
// -----------------------------------------------------------------------------
module ifetch_obuf
   import ifetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_W   = PC_WIDTH,
   parameter int unsigned INST_W = INST_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic              flush_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [PC_W-1:0]   pc_o
);

   logic              valid_d, valid_q;
   logic [INST_W-1:0] inst_d,  inst_q;
   logic [PC_W-1:0]   pc_d,    pc_q;

   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      // Flush wins over everything; a load is never requested together with
      // a flush, but the priority keeps the slot empty if it ever were.
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         inst_d  = inst_i;
         pc_d    = pc_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign inst_o  = inst_q;
   assign pc_o    = pc_q;

endmodule : ifetch_obuf

// File: rtl/ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifetch_ctrl
//   Instruction-fetch controller. Issues one memory read per PC, hands back
//   pc+4 to the PC register and holds it (stall) until the read is accepted,
//   and buffers one returned instruction for decode. A flush withdraws any
//   pending request and discards the response of an in-flight one.
//   Ports:
//     clk               in   clock
//     rst_n             in   synchronous reset, active low
//     pc_i              in   current PC from PC register
//     pc_next_o         out  pc_i + 4 (wraps modulo 2^PC_WIDTH)
//     stall_o           out  hold PC register
//     flush_i           in   pipeline flush
//     imem_req_valid_o  out  fetch request valid
//     imem_req_ready_i  in   memory accepts request
//     imem_req_addr_o   out  fetch address
//     imem_rsp_valid_i  in   read data valid
//     imem_rsp_data_i   in   read data
//     id_valid_o        out  instruction valid to decode
//     id_ready_i        in   decode accepts instruction
//     id_inst_o         out  fetched instruction
//     id_pc_o           out  PC of id_inst_o
// -----------------------------------------------------------------------------
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_W   = PC_WIDTH,
   parameter int unsigned INST_W = INST_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   pc_i,
   output logic [PC_W-1:0]   pc_next_o,
   output logic              stall_o,
   input  logic              flush_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [PC_W-1:0]   imem_req_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [INST_W-1:0] imem_rsp_data_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [INST_W-1:0] id_inst_o,
   output logic [PC_W-1:0]   id_pc_o
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   if_state_e       state_d, state_q;
   logic [PC_W-1:0] pc_hold_d, pc_hold_q;

   logic req_valid;
   logic fire;
   logic obuf_load;
   logic obuf_valid;

   // A request goes out only with nothing outstanding and with the output
   // slot empty or draining this cycle, so the slot always has room for the
   // response. Reset is synchronous, so the request is also masked directly
   // while rst_n is low.
   assign req_valid = rst_n && (state_q == S_REQ) && !flush_i &&
                      (!obuf_valid || id_ready_i);
   assign fire      = req_valid && imem_req_ready_i;

   assign imem_req_valid_o = req_valid;
   assign imem_req_addr_o  = pc_i;
   assign pc_next_o        = pc_i + PC_STEP;

   // Releasing the PC on flush lets the PC register load the flush target.
   assign stall_o = !rst_n || (!fire && !flush_i);

   always_comb begin
      state_d   = state_q;
      pc_hold_d = pc_hold_q;
      obuf_load = 1'b0;
      unique case (state_q)
         S_REQ: begin
            // Responses seen here are stale and ignored.
            if (fire) begin
               pc_hold_d = pc_i;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid_i) begin
               obuf_load = !flush_i;
               state_d   = S_REQ;
            end else if (flush_i) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rsp_valid_i) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_REQ;
         pc_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_hold_q <= pc_hold_d;
      end
   end

   ifetch_obuf #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_obuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (obuf_load),
      .inst_i  (imem_rsp_data_i),
      .pc_i    (pc_hold_q),
      .flush_i (flush_i),
      .ready_i (id_ready_i),
      .valid_o (obuf_valid),
      .inst_o  (id_inst_o),
      .pc_o    (id_pc_o)
   );

   assign id_valid_o = obuf_valid;

endmodule : ifetch_ctrl

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_i;
   logic [31:0] pc_next_o;
   logic        stall_o;
   logic        flush_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifetch_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pc_i             (pc_i),
      .pc_next_o        (pc_next_o),
      .stall_o          (stall_o),
      .flush_i          (flush_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .id_valid_o       (id_valid_o),
      .id_ready_i       (id_ready_i),
      .id_inst_o        (id_inst_o),
      .id_pc_o          (id_pc_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle #2 after the edge; inputs are then changed
   // and outputs sampled mid-cycle, well away from the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n            = 1'b0;
      pc_i             = 32'h0;
      flush_i          = 1'b0;
      imem_req_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
      id_ready_i       = 1'b1;
      #2;
      check("rst_req_valid", {31'b0, imem_req_valid_o}, 32'h0);
      check("rst_stall",     {31'b0, stall_o},          32'h1);
      tick();
      tick();
      check("rst_id_valid", {31'b0, id_valid_o}, 32'h0);
      check("rst_id_inst",  id_inst_o,           32'h0);
      check("rst_id_pc",    id_pc_o,             32'h0);

      // ---- 1: sequential fetch with a one-cycle memory ----
      rst_n = 1'b1;
      #1;
      check("t1_req_valid0", {31'b0, imem_req_valid_o}, 32'h1);
      check("t1_addr0",      imem_req_addr_o,           32'h0);
      check("t1_stall0",     {31'b0, stall_o},          32'h0);
      check("t1_pcnext0",    pc_next_o,                 32'h4);
      tick();
      pc_i = 32'h4; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0000;
      #1;
      check("t1_wait_req",   {31'b0, imem_req_valid_o}, 32'h0);
      check("t1_wait_stall", {31'b0, stall_o},          32'h1);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("t1_id_valid0", {31'b0, id_valid_o}, 32'h1);
      check("t1_id_inst0",  id_inst_o,           32'hAAAA_0000);
      check("t1_id_pc0",    id_pc_o,             32'h0);
      check("t1_addr4",     imem_req_addr_o,     32'h4);
      check("t1_req4",      {31'b0, imem_req_valid_o}, 32'h1);
      tick();
      pc_i = 32'h8; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0004;
      #1;
      check("t1_id_drained", {31'b0, id_valid_o}, 32'h0);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("t1_id_pc4",   id_pc_o,         32'h4);
      check("t1_id_inst4", id_inst_o,       32'hAAAA_0004);
      check("t1_addr8",    imem_req_addr_o, 32'h8);
      tick();
      pc_i = 32'hC; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0008;
      tick();
      imem_rsp_valid_i = 1'b0;
      // ---- 2: memory not ready for three cycles at 0x100 ----
      pc_i = 32'h100; imem_req_ready_i = 1'b0;
      #1;
      check("t1_id_pc8",   id_pc_o,   32'h8);
      check("t1_id_inst8", id_inst_o, 32'hAAAA_0008);
      for (int i = 0; i < 3; i++) begin
         check("t2_stall",     {31'b0, stall_o},          32'h1);
         check("t2_req_valid", {31'b0, imem_req_valid_o}, 32'h1);
         check("t2_addr",      imem_req_addr_o,           32'h100);
         tick();
      end
      imem_req_ready_i = 1'b1;
      #1;
      check("t2_fire_stall", {31'b0, stall_o}, 32'h0);
      check("t2_pcnext",     pc_next_o,        32'h104);
      tick();
      pc_i = 32'h104; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h1234_5678;
      tick();
      imem_rsp_valid_i = 1'b0; pc_i = 32'h20;
      #1;
      check("t2_id_pc",   id_pc_o,   32'h100);
      check("t2_id_inst", id_inst_o, 32'h1234_5678);
      tick();

      // ---- 3: flush while waiting on 0x20, late response dropped ----
      pc_i = 32'h24; flush_i = 1'b1;
      #1;
      check("t3_flush_stall", {31'b0, stall_o},          32'h0);
      check("t3_flush_req",   {31'b0, imem_req_valid_o}, 32'h0);
      tick();
      flush_i = 1'b0; pc_i = 32'h80;
      #1;
      check("t3_drop_req",   {31'b0, imem_req_valid_o}, 32'h0);
      check("t3_drop_stall", {31'b0, stall_o},          32'h1);
      tick();
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF;
      #1;
      check("t3_rsp_idv", {31'b0, id_valid_o}, 32'h0);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("t3_after_idv", {31'b0, id_valid_o},       32'h0);
      check("t3_next_req",  {31'b0, imem_req_valid_o}, 32'h1);
      check("t3_next_addr", imem_req_addr_o,           32'h80);
      tick();

      // ---- 4: flush coincident with the response ----
      pc_i = 32'h84; flush_i = 1'b1; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0BAD_0BAD;
      tick();
      flush_i = 1'b0; imem_rsp_valid_i = 1'b0; pc_i = 32'h200;
      #1;
      check("t4_idv",  {31'b0, id_valid_o},       32'h0);
      check("t4_req",  {31'b0, imem_req_valid_o}, 32'h1);
      check("t4_addr", imem_req_addr_o,           32'h200);
      tick();

      // ---- 5: decode back-pressure ----
      pc_i = 32'h204; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h55AA_55AA; id_ready_i = 1'b0;
      tick();
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t5_idv",   {31'b0, id_valid_o},       32'h1);
         check("t5_inst",  id_inst_o,                 32'h55AA_55AA);
         check("t5_pc",    id_pc_o,                   32'h200);
         check("t5_noreq", {31'b0, imem_req_valid_o}, 32'h0);
         check("t5_stall", {31'b0, stall_o},          32'h1);
         tick();
      end
      id_ready_i = 1'b1;
      #1;
      check("t5_req_rise",  {31'b0, imem_req_valid_o}, 32'h1);
      check("t5_fire",      {31'b0, stall_o},          32'h0);
      check("t5_addr",      imem_req_addr_o,           32'h204);
      tick();

      // ---- 6: PC wrap; reset while waiting; stale response ignored ----
      pc_i = 32'hFFFF_FFFC; rst_n = 1'b0;
      #1;
      check("t6_wrap",      pc_next_o,                 32'h0);
      check("t6_rst_req",   {31'b0, imem_req_valid_o}, 32'h0);
      check("t6_rst_stall", {31'b0, stall_o},          32'h1);
      tick();
      rst_n = 1'b1; imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h9999_9999;
      #1;
      check("t6_req_after_rst", {31'b0, imem_req_valid_o}, 32'h1);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("t6_stale_idv",  {31'b0, id_valid_o},       32'h0);
      check("t6_stale_inst", id_inst_o,                 32'h0);
      check("t6_req_held",   {31'b0, imem_req_valid_o}, 32'h1);
      check("t6_addr",       imem_req_addr_o,           32'hFFFF_FFFC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ifetch_ctrl
